pong_game_core: RTL and testbench

- Two-player, parametrised successor of the single-paddle pong datapath.
- Two vertical paddles, each driven by its own quadrature encoder, plus a ball with configurable size and speed.
- Serve/play/point/game-over state machine with per-player score counters.
- Consumes beam counters from the existing hvsync generator and emits registered 1-bit RGB.

---
 rtl/pong_game_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pong_game_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_core.sv
// Two-player pong datapath: quadrature-driven paddles, ball kinematics with edge-midpoint
// collision probes, serve/play/point/over sequencing, and a registered 1-bit RGB pixel.
module pong_game_core #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 16,
  parameter int PADDLE_LEN   = 96,
  parameter int SPEED        = 2,
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         cnt_x,
  input  logic [9:0]         cnt_y,
  input  logic               in_display,
  input  logic [1:0]         quad_a,
  input  logic [1:0]         quad_b,
  input  logic               start,
  output logic               vga_r,
  output logic               vga_g,
  output logic               vga_b,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

  localparam logic [10:0] BORDER    = 11'd8;
  localparam logic [10:0] WALL_BOT  = 11'(V_ACTIVE - 8);
  localparam logic [10:0] LPAD_X0   = 11'd16;
  localparam logic [10:0] LPAD_X1   = 11'd23;
  localparam logic [10:0] RPAD_X0   = 11'(H_ACTIVE - 24);
  localparam logic [10:0] RPAD_X1   = 11'(H_ACTIVE - 17);
  localparam logic [10:0] PAD_LEN   = 11'(PADDLE_LEN);
  localparam logic [10:0] PAD_MIN   = 11'd8;
  localparam logic [10:0] PAD_MAX   = 11'(V_ACTIVE - 8 - PADDLE_LEN);
  localparam logic [10:0] PAD_INIT  = 11'((V_ACTIVE - PADDLE_LEN) / 2);
  localparam logic [10:0] BALL      = 11'(BALL_SIZE);
  localparam logic [10:0] BALL_HALF = 11'(BALL_SIZE / 2);
  localparam logic [10:0] BALL_X0   = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] BALL_Y0   = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] GOAL_R    = 11'(H_ACTIVE - 8);
  localparam logic [10:0] TICK_Y    = 11'(V_ACTIVE);
  localparam logic [7:0]  NET_COL   = 8'(H_ACTIVE / 8);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] POINT_LAST = FRAME_W'(POINT_FRAMES - 1);

  // Moves a paddle one line per decoded encoder step, dropping steps at the travel limits.
  function automatic logic [10:0] pad_step(input logic [10:0] pad,
                                           input logic [2:0]  a,
                                           input logic [2:0]  b);
    logic step;
    logic down;
    step     = a[2] ^ a[1] ^ b[2] ^ b[1];
    down     = a[2] ^ b[1];
    pad_step = pad;
    if (step && down && (pad < PAD_MAX)) begin
      pad_step = pad + 11'd1;
    end else if (step && !down && (pad > PAD_MIN)) begin
      pad_step = pad - 11'd1;
    end
  endfunction

  logic [2:0]  qa_l_q, qb_l_q, qa_r_q, qb_r_q;
  logic [10:0] pad_l_q, pad_r_q;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic [10:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic                hit_x1_q, hit_x2_q, hit_y1_q, hit_y2_q;
  logic                dir_x_upd, dir_y_upd;
  logic [2:0]          rgb_q, rgb_d;

  logic [10:0] cx, cy;
  logic        tick, wall, pad_l_hit, pad_r_hit, bounce, ball_pix, net;
  logic        probe_x1, probe_x2, probe_y1, probe_y2;

  // Encoder phases are asynchronous: the two oldest taps of each shift register feed the decoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qa_l_q  <= 3'b000;
      qb_l_q  <= 3'b000;
      qa_r_q  <= 3'b000;
      qb_r_q  <= 3'b000;
      pad_l_q <= PAD_INIT;
      pad_r_q <= PAD_INIT;
    end else begin
      qa_l_q  <= {qa_l_q[1:0], quad_a[0]};
      qb_l_q  <= {qb_l_q[1:0], quad_b[0]};
      qa_r_q  <= {qa_r_q[1:0], quad_a[1]};
      qb_r_q  <= {qb_r_q[1:0], quad_b[1]};
      pad_l_q <= pad_step(pad_l_q, qa_l_q, qb_l_q);
      pad_r_q <= pad_step(pad_r_q, qa_r_q, qb_r_q);
    end
  end

  assign cx = {1'b0, cnt_x};
  assign cy = {1'b0, cnt_y};

  assign tick      = (cx == 11'd0) && (cy == TICK_Y);
  assign wall      = (cy < BORDER) || (cy >= WALL_BOT);
  assign pad_l_hit = (cx >= LPAD_X0) && (cx <= LPAD_X1) &&
                     (cy >= pad_l_q) && (cy < pad_l_q + PAD_LEN);
  assign pad_r_hit = (cx >= RPAD_X0) && (cx <= RPAD_X1) &&
                     (cy >= pad_r_q) && (cy < pad_r_q + PAD_LEN);
  assign bounce    = wall || pad_l_hit || pad_r_hit;
  assign ball_pix  = (state_q != ST_OVER) &&
                     (cx >= ball_x_q) && (cx < ball_x_q + BALL) &&
                     (cy >= ball_y_q) && (cy < ball_y_q + BALL);
  assign net       = (cnt_x[9:2] == NET_COL) && cnt_y[3];

  assign probe_x1 = (cx == ball_x_q)             && (cy == ball_y_q + BALL_HALF);
  assign probe_x2 = (cx == ball_x_q + BALL)      && (cy == ball_y_q + BALL_HALF);
  assign probe_y1 = (cx == ball_x_q + BALL_HALF) && (cy == ball_y_q);
  assign probe_y2 = (cx == ball_x_q + BALL_HALF) && (cy == ball_y_q + BALL);

  // Latches accumulate over the visible frame and are consumed by the tick, which wins over a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_x1_q <= 1'b0;
      hit_x2_q <= 1'b0;
      hit_y1_q <= 1'b0;
      hit_y2_q <= 1'b0;
    end else if (tick) begin
      hit_x1_q <= 1'b0;
      hit_x2_q <= 1'b0;
      hit_y1_q <= 1'b0;
      hit_y2_q <= 1'b0;
    end else begin
      hit_x1_q <= hit_x1_q | (bounce & probe_x1);
      hit_x2_q <= hit_x2_q | (bounce & probe_x2);
      hit_y1_q <= hit_y1_q | (bounce & probe_y1);
      hit_y2_q <= hit_y2_q | (bounce & probe_y2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SERVE;
      frame_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      ball_x_q  <= BALL_X0;
      ball_y_q  <= BALL_Y0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;

    // The far-edge probe wins when both sides of an axis were hit.
    dir_x_upd = dir_x_q;
    if (hit_x2_q)      dir_x_upd = 1'b0;
    else if (hit_x1_q) dir_x_upd = 1'b1;
    dir_y_upd = dir_y_q;
    if (hit_y2_q)      dir_y_upd = 1'b0;
    else if (hit_y1_q) dir_y_upd = 1'b1;

    case (state_q)
      ST_SERVE: begin
        ball_x_d = BALL_X0;
        ball_y_d = BALL_Y0;
        if (tick) begin
          if (frame_q == SERVE_LAST) begin
            frame_d = '0;
            state_d = ST_PLAY;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          dir_y_d = dir_y_upd;
          if (ball_x_q < BORDER) begin
            if (score_r_q < WIN) score_r_d = score_r_q + SCORE_W'(1);
            dir_x_d = 1'b0;
            frame_d = '0;
            state_d = ST_POINT;
          end else if (ball_x_q + BALL > GOAL_R) begin
            if (score_l_q < WIN) score_l_d = score_l_q + SCORE_W'(1);
            dir_x_d = 1'b1;
            frame_d = '0;
            state_d = ST_POINT;
          end else begin
            dir_x_d = dir_x_upd;
            if (!(hit_x1_q && hit_x2_q)) begin
              ball_x_d = dir_x_upd ? (ball_x_q + STEP) : (ball_x_q - STEP);
            end
            if (!(hit_y1_q && hit_y2_q)) begin
              ball_y_d = dir_y_upd ? (ball_y_q + STEP) : (ball_y_q - STEP);
            end
          end
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (frame_q == POINT_LAST) begin
            frame_d = '0;
            if ((score_l_q == WIN) || (score_r_q == WIN)) begin
              state_d = ST_OVER;
            end else begin
              ball_x_d = BALL_X0;
              ball_y_d = BALL_Y0;
              state_d  = ST_SERVE;
            end
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          score_l_d = '0;
          score_r_d = '0;
          ball_x_d  = BALL_X0;
          ball_y_d  = BALL_Y0;
          dir_x_d   = 1'b1;
          frame_d   = '0;
          state_d   = ST_SERVE;
        end
      end
    endcase
  end

  always_comb begin
    rgb_d = 3'b000;
    if (in_display) begin
      if (bounce)        rgb_d = 3'b111;
      else if (ball_pix) rgb_d = 3'b110;
      else if (net)      rgb_d = 3'b010;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= 3'b000;
    else       rgb_q <= rgb_d;
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them against the DUT whenever a check is requested.
module tb_pong_game_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] cnt_x, cnt_y;
  logic       in_display;
  logic [1:0] quad_a, quad_b;
  logic       start;
  logic       vga_r, vga_g, vga_b;
  logic [3:0] score_l, score_r;
  logic [1:0] state;

  pong_game_core dut (
    .clk(clk), .reset(reset), .cnt_x(cnt_x), .cnt_y(cnt_y), .in_display(in_display),
    .quad_a(quad_a), .quad_b(quad_b), .start(start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [2:0] rgb;
  } exp_t;

  exp_t       sb_q[$];
  logic       chk_req = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] e_st = 2'd0;
  logic [3:0] e_sl = 4'd0;
  logic [3:0] e_sr = 4'd0;
  int         ph_l = 0;
  int         ph_r = 0;

  // Monitor: consumes one expected record per requested sample.
  always @(negedge clk) begin
    if (chk_req) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got a sample request, required a queued expectation");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({state, score_l, score_r, vga_r, vga_g, vga_b} !== {e.st, e.sl, e.sr, e.rgb}) begin
          n_fail++;
          $display("FAIL %s: got state=%0d score_l=%0d score_r=%0d rgb=%b, required state=%0d score_l=%0d score_r=%0d rgb=%b",
                   e.name, state, score_l, score_r, {vga_r, vga_g, vga_b}, e.st, e.sl, e.sr, e.rgb);
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion, required end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic idle();
    cnt_x = 10'd700;
    cnt_y = 10'd300;
    in_display = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] rgb);
    exp_t e;
    e.name = nm; e.st = e_st; e.sl = e_sl; e.sr = e_sr; e.rgb = rgb;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic expect_state(input string nm);
    expect_out(nm, 3'b000);
  endtask

  task automatic pixel(input int x, input int y, input logic disp);
    cnt_x = 10'(x);
    cnt_y = 10'(y);
    in_display = disp;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic expect_pix(input string nm, input int x, input int y, input logic disp,
                            input logic [2:0] rgb);
    pixel(x, y, disp);
    expect_out(nm, rgb);
  endtask

  task automatic tick();
    pixel(0, 480, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_ball(input string nm, input int x, input int y);
    expect_pix({nm, "_tl"}, x, y, 1'b1, 3'b110);
    expect_pix({nm, "_left"}, x - 1, y, 1'b1, 3'b000);
    expect_pix({nm, "_br"}, x + 15, y + 15, 1'b1, 3'b110);
    if (y + 16 < 472) expect_pix({nm, "_below"}, x + 15, y + 16, 1'b1, 3'b000);
  endtask

  function automatic logic [1:0] quad_phase(input int ph);
    case (ph)
      0: quad_phase = 2'b00;
      1: quad_phase = 2'b01;
      2: quad_phase = 2'b11;
      default: quad_phase = 2'b10;
    endcase
  endfunction

  // Phase value is {A,B}; forward rotation (B leading) moves the paddle down.
  task automatic quad_steps(input int player, input int n, input logic fwd);
    logic [1:0] ab;
    for (int i = 0; i < n; i++) begin
      if (player == 0) begin
        ph_l = fwd ? (ph_l + 1) % 4 : (ph_l + 3) % 4;
        ab = quad_phase(ph_l);
        quad_a[0] = ab[1];
        quad_b[0] = ab[0];
      end else begin
        ph_r = fwd ? (ph_r + 1) % 4 : (ph_r + 3) % 4;
        ab = quad_phase(ph_r);
        quad_a[1] = ab[1];
        quad_b[1] = ab[0];
      end
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    quad_a = 2'b00;
    quad_b = 2'b00;
    idle();
    repeat (2) @(posedge clk);
    #1 expect_state("reset_state");
    reset = 1'b0;

    check_ball("ball_reset", 312, 232);
    expect_pix("net_on", 320, 24, 1'b1, 3'b010);
    expect_pix("net_gap", 320, 16, 1'b1, 3'b000);

    ticks(59);
    expect_state("serve_59_ticks");
    check_ball("ball_serve_held", 312, 232);
    tick();
    e_st = 2'd1;
    expect_state("play_after_60");
    tick();
    check_ball("ball_first_move", 314, 234);

    quad_steps(0, 200, 1'b1);
    expect_pix("padl_clamped_top", 20, 376, 1'b1, 3'b111);
    expect_pix("padl_clamped_above", 20, 375, 1'b1, 3'b000);
    quad_steps(0, 10, 1'b1);
    expect_pix("padl_stays_clamped", 20, 375, 1'b1, 3'b000);
    quad_steps(0, 1, 1'b0);
    expect_pix("padl_reverse_one", 20, 375, 1'b1, 3'b111);
    expect_pix("pix_white", 20, 385, 1'b1, 3'b111);
    expect_pix("pix_blanked", 20, 385, 1'b0, 3'b000);
    quad_steps(0, 400, 1'b0);
    expect_pix("padl_min_inside", 20, 103, 1'b1, 3'b111);
    expect_pix("padl_min_below", 20, 104, 1'b1, 3'b000);
    quad_steps(1, 200, 1'b1);
    expect_pix("padr_clamped_top", 620, 376, 1'b1, 3'b111);
    expect_pix("padr_clamped_above", 620, 375, 1'b1, 3'b000);

    ticks(111);
    check_ball("ball_near_floor", 536, 456);
    pixel(544, 472, 1'b0);
    tick();
    check_ball("ball_floor_bounce", 538, 454);

    ticks(31);
    check_ball("ball_near_rpad", 600, 392);
    pixel(616, 400, 1'b0);
    tick();
    check_ball("ball_rpad_bounce", 598, 390);

    ticks(191);
    check_ball("ball_near_ceiling", 216, 8);
    tick();
    pixel(222, 6, 1'b0);
    tick();
    check_ball("ball_ceiling_bounce", 212, 8);

    ticks(103);
    check_ball("ball_at_left_goal", 6, 214);
    expect_state("play_before_goal");
    tick();
    e_st = 2'd2;
    e_sr = 4'd1;
    expect_state("goal_right_scores");
    check_ball("ball_frozen_point", 6, 214);
    ticks(29);
    expect_state("point_29_ticks");
    tick();
    e_st = 2'd0;
    expect_state("serve_after_point");
    check_ball("ball_recentred", 312, 232);
    pulse_start();
    expect_state("start_ignored_serve");

    ticks(10);
    #2 reset = 1'b1;
    e_st = 2'd0;
    e_sr = 4'd0;
    expect_state("reset_mid_game");
    reset = 1'b0;

    for (int p = 1; p <= 5; p++) begin
      ticks(60);
      e_st = 2'd1;
      expect_state("serve_to_play");
      if (p == 2) begin
        pulse_start();
        expect_state("start_ignored_play");
      end
      ticks(153);
      expect_state("play_at_right_edge");
      tick();
      e_st = 2'd2;
      e_sl = 4'(p);
      expect_state("goal_left_scores");
      ticks(30);
      e_st = (p == 5) ? 2'd3 : 2'd0;
      expect_state("point_exit");
    end

    tick();
    expect_state("over_holds");
    pulse_start();
    e_st = 2'd0;
    e_sl = 4'd0;
    e_sr = 4'd0;
    expect_state("start_leaves_over");
    check_ball("ball_after_restart", 312, 232);

    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
